// File: rtl/synth_sample_gen.sv
// synth_sample_gen
// Phase-accumulator tone generator that produces one unsigned CODE_W-bit sample
// per accepted synth_valid/synth_ready handshake. The waveform is selectable.
// Volume is an arithmetic right shift about midscale. The note gate forces
// midscale when it is low.
//
// Ports
//   clk               in   system clock
//   rst               in   synchronous active-high reset
//   fcw               in   frequency control word, sampled on the transfer edge
//   wave_sel          in   00 saw, 01 square, 10 triangle, 11 DC midscale
//   volume            in   right shift applied to the signed sample (0 = full)
//   note_en           in   0 forces the output sample to midscale
//   synth_ready       in   consumer ready (a 1-cycle pulse is allowed)
//   synth_valid       out  sample on scaled_synth_code is valid
//   scaled_synth_code out  unsigned output sample
module synth_sample_gen #(
   parameter int unsigned PHASE_W = 24,
   parameter int unsigned CODE_W  = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PHASE_W-1:0] fcw,
   input  logic [1:0]         wave_sel,
   input  logic [2:0]         volume,
   input  logic               note_en,
   input  logic               synth_ready,
   output logic               synth_valid,
   output logic [CODE_W-1:0]  scaled_synth_code
);

   localparam logic [1:0] ST_WAVE  = 2'd0;
   localparam logic [1:0] ST_SCALE = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam logic [CODE_W-1:0] MID = {1'b1, {(CODE_W-1){1'b0}}};

   logic [1:0]         state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [CODE_W-1:0]  wave_raw_q, wave_raw_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic               valid_q, valid_d;

   logic [CODE_W-1:0]  p;
   logic [CODE_W-1:0]  wave_val;
   logic signed [CODE_W:0] diff_s;
   logic signed [CODE_W:0] shr_s;
   logic [CODE_W-1:0]  scaled;

   assign p = phase_q[PHASE_W-1 -: CODE_W];

   // Waveform lookup from the top bits of the phase
   always_comb begin
      wave_val = MID;
      case (wave_sel)
         2'b00:   wave_val = p;
         2'b01:   wave_val = {CODE_W{p[CODE_W-1]}};
         2'b10:   wave_val = {(p[CODE_W-1] ? ~p[CODE_W-2:0] : p[CODE_W-2:0]), 1'b0};
         default: wave_val = MID;
      endcase
   end

   // Attenuate about midscale; the shifted value always lands back in range
   always_comb begin
      diff_s = $signed({1'b0, wave_raw_q}) - $signed({1'b0, MID});
      shr_s  = diff_s >>> volume;
      scaled = CODE_W'($unsigned(shr_s) + {1'b0, MID});
   end

   // Next-state and datapath updates
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      wave_raw_d = wave_raw_q;
      code_d     = code_q;
      case (state_q)
         ST_WAVE: begin
            wave_raw_d = wave_val;
            state_d    = ST_SCALE;
         end
         ST_SCALE: begin
            code_d  = note_en ? scaled : MID;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (synth_ready) begin
               phase_d = phase_q + fcw;
               state_d = ST_WAVE;
            end
         end
         default: state_d = ST_WAVE;
      endcase
      valid_d = (state_d == ST_HOLD);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_WAVE;
         phase_q    <= '0;
         wave_raw_q <= '0;
         code_q     <= MID;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         wave_raw_q <= wave_raw_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
      end
   end

   assign synth_valid       = valid_q;
   assign scaled_synth_code = code_q;

endmodule

// File: tb/tb_synth_sample_gen.sv
// Testbench for synth_sample_gen: table-driven four-sample vectors plus
// hand-written sequences for reset, handshake timing and stall behaviour.
module tb_synth_sample_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] fcw;
   logic [1:0]  wave_sel;
   logic [2:0]  volume;
   logic        note_en;
   logic        synth_ready;
   logic        synth_valid;
   logic [9:0]  scaled_synth_code;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   synth_sample_gen #(.PHASE_W(24), .CODE_W(10)) dut (
      .clk               (clk),
      .rst               (rst),
      .fcw               (fcw),
      .wave_sel          (wave_sel),
      .volume            (volume),
      .note_en           (note_en),
      .synth_ready       (synth_ready),
      .synth_valid       (synth_valid),
      .scaled_synth_code (scaled_synth_code)
   );

   typedef struct {
      logic [1:0]  ws;
      logic [2:0]  vol;
      logic        en;
      logic [23:0] f;
      logic [9:0]  e0;
      logic [9:0]  e1;
      logic [9:0]  e2;
      logic [9:0]  e3;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for n cycles and check the reset outputs
   task automatic do_reset(input int n);
      rst = 1'b1;
      synth_ready = 1'b0;
      repeat (n) tick();
      check("reset_valid", int'(synth_valid), 0);
      check("reset_code", int'(scaled_synth_code), 512);
      rst = 1'b0;
   endtask

   // Wait (bounded) for valid, check the code, then accept with a 1-cycle ready
   task automatic get_sample(input string name, input int exp);
      int waited = 0;
      while (!synth_valid && waited < 10) begin
         tick();
         waited++;
      end
      if (!synth_valid) begin
         check({name, "_timeout"}, 0, 1);
      end else begin
         check(name, int'(scaled_synth_code), exp);
      end
      synth_ready = 1'b1;
      tick();
      synth_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      fcw = 24'h0;
      wave_sel = 2'b00;
      volume = 3'd0;
      note_en = 1'b1;
      synth_ready = 1'b0;

      // 1. Reset values and first-valid latency
      do_reset(5);
      tick();
      check("first_edge_valid", int'(synth_valid), 0);
      tick();
      check("second_edge_valid", int'(synth_valid), 1);
      check("first_code", int'(scaled_synth_code), 0);

      // Table of four-sample sequences from phase 0
      vecs[0] = '{2'd0, 3'd0, 1'b1, 24'h400000, 10'd0,   10'd256, 10'd512,  10'd768};
      vecs[1] = '{2'd1, 3'd0, 1'b1, 24'h400000, 10'd0,   10'd0,   10'd1023, 10'd1023};
      vecs[2] = '{2'd2, 3'd0, 1'b1, 24'h400000, 10'd0,   10'd512, 10'd1022, 10'd510};
      vecs[3] = '{2'd1, 3'd1, 1'b1, 24'h400000, 10'd256, 10'd256, 10'd767,  10'd767};
      vecs[4] = '{2'd1, 3'd7, 1'b1, 24'h400000, 10'd508, 10'd508, 10'd515,  10'd515};
      vecs[5] = '{2'd1, 3'd0, 1'b0, 24'h400000, 10'd512, 10'd512, 10'd512,  10'd512};
      vecs[6] = '{2'd3, 3'd0, 1'b1, 24'h400000, 10'd512, 10'd512, 10'd512,  10'd512};
      vecs[7] = '{2'd0, 3'd2, 1'b1, 24'h400000, 10'd384, 10'd448, 10'd512,  10'd576};
      vecs[8] = '{2'd0, 3'd0, 1'b1, 24'hC00000, 10'd0,   10'd768, 10'd512,  10'd256};

      for (int i = 0; i < 9; i++) begin
         wave_sel = vecs[i].ws;
         volume   = vecs[i].vol;
         note_en  = vecs[i].en;
         fcw      = vecs[i].f;
         do_reset(2);
         get_sample($sformatf("vec%0d_s0", i), int'(vecs[i].e0));
         get_sample($sformatf("vec%0d_s1", i), int'(vecs[i].e1));
         get_sample($sformatf("vec%0d_s2", i), int'(vecs[i].e2));
         get_sample($sformatf("vec%0d_s3", i), int'(vecs[i].e3));
      end

      // fcw = 0 gives a constant sample
      wave_sel = 2'd0; volume = 3'd0; note_en = 1'b1; fcw = 24'h0;
      do_reset(2);
      for (int i = 0; i < 3; i++) get_sample($sformatf("fcw0_s%0d", i), 0);

      // 2. Saw ramp through every code and the wrap back to 0
      fcw = 24'h004000;
      do_reset(2);
      for (int i = 0; i < 1025; i++) get_sample($sformatf("ramp_%0d", i), i % 1024);

      // 5. Ready during WAVE/SCALE is ignored, then ready held high
      wave_sel = 2'd0; fcw = 24'h400000;
      do_reset(2);
      get_sample("pre_ign_s0", 0);
      synth_ready = 1'b1;
      tick();
      tick();
      synth_ready = 1'b0;
      check("ign_valid", int'(synth_valid), 1);
      check("ign_code", int'(scaled_synth_code), 256);
      synth_ready = 1'b1;
      for (int j = 1; j <= 9; j++) begin
         tick();
         check($sformatf("stream_valid_%0d", j), int'(synth_valid), (j % 3 == 0) ? 1 : 0);
         if (j % 3 == 0)
            check($sformatf("stream_code_%0d", j), int'(scaled_synth_code), (256 * (1 + j / 3)) % 1024);
      end
      synth_ready = 1'b0;

      // Stability while stalled in HOLD; inputs changing do not disturb the held sample
      volume = 3'd3; note_en = 1'b0; wave_sel = 2'd1;
      for (int j = 0; j < 6; j++) begin
         tick();
         check($sformatf("stall_valid_%0d", j), int'(synth_valid), 1);
         check($sformatf("stall_code_%0d", j), int'(scaled_synth_code), 0);
      end
      volume = 3'd0; note_en = 1'b1; wave_sel = 2'd0;

      // 6. Reset asserted in SCALE drops the sample and restarts from phase 0
      get_sample("pre_rst_s0", 0);
      get_sample("pre_rst_s1", 256);
      tick();
      rst = 1'b1;
      tick();
      check("rst_scale_valid", int'(synth_valid), 0);
      check("rst_scale_code", int'(scaled_synth_code), 512);
      rst = 1'b0;
      tick();
      check("restart_edge1_valid", int'(synth_valid), 0);
      tick();
      check("restart_edge2_valid", int'(synth_valid), 1);
      check("restart_code", int'(scaled_synth_code), 0);
      get_sample("restart_s0", 0);
      get_sample("restart_s1", 256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
